// File: rtl/oam_dma.sv
// Sprite DMA engine: snoops the CPU trigger write, halts the CPU and copies one
// page from memory into the OAM data register, one read/write pair per byte.
module oam_dma #(
   parameter int unsigned                  WIDTH         = 8,
   parameter int unsigned                  ADDR_WIDTH    = 16,
   parameter logic [ADDR_WIDTH-1:0]        TRIG_ADDR     = 16'h4014,
   parameter logic [ADDR_WIDTH-1:0]        OAM_DATA_ADDR = 16'h2004,
   parameter int unsigned                  LENGTH        = 256
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic                  cpu_we,
   input  logic [WIDTH-1:0]      cpu_din,
   input  logic                  odd_cycle,
   output logic [ADDR_WIDTH-1:0] bus_addr,
   output logic                  bus_we,
   output logic [WIDTH-1:0]      bus_dout,
   input  logic [WIDTH-1:0]      bus_din,
   output logic                  halt,
   output logic                  done
);

   typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;

   localparam logic [7:0] IDX_LAST = 8'(LENGTH - 1);

   state_t           state;
   logic [WIDTH-1:0] page;
   logic [7:0]       idx;
   logic [WIDTH-1:0] data;

   // Outputs are loaded on the edge that enters the state they belong to.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         page     <= '0;
         idx      <= '0;
         data     <= '0;
         halt     <= 1'b0;
         bus_we   <= 1'b0;
         bus_addr <= '0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (cpu_we && cpu_addr == TRIG_ADDR) begin
                  page  <= cpu_din;
                  idx   <= '0;
                  halt  <= 1'b1;
                  state <= HALT;
               end
            end
            HALT: begin
               if (odd_cycle) begin
                  state <= ALIGN;
               end else begin
                  bus_addr <= ADDR_WIDTH'({page, idx});
                  state    <= READ;
               end
            end
            ALIGN: begin
               bus_addr <= ADDR_WIDTH'({page, idx});
               state    <= READ;
            end
            READ: begin
               data     <= bus_din;
               bus_addr <= OAM_DATA_ADDR;
               bus_we   <= 1'b1;
               state    <= WRITE;
            end
            WRITE: begin
               bus_we <= 1'b0;
               if (idx == IDX_LAST) begin
                  bus_addr <= '0;
                  halt     <= 1'b0;
                  done     <= 1'b1;
                  state    <= IDLE;
               end else begin
                  idx      <= idx + 8'd1;
                  bus_addr <= ADDR_WIDTH'({page, idx + 8'd1});
                  state    <= READ;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // data only reaches the bus while the write strobe is up.
   assign bus_dout = bus_we ? data : '0;

endmodule
